// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per cycle, LSB first,
// and presents the result with carry/borrow, zero and signed-overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             addsub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             cf,
  output logic             zero,
  output logic             of
);

  localparam int N   = WIDTH / CHUNK;
  localparam int CW  = $clog2(N + 1);
  localparam int CP1 = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] aQ, aD, bQ, bD, sumQ, sumD, fQ, fD;
  logic [CW-1:0]    cntQ, cntD;
  logic             carryQ, carryD, subQ, subD;
  logic             cfQ, cfD, zeroQ, zeroD, ofQ, ofD;
  logic             accept, lastChunk;
  logic [CHUNK:0]   chunkSum;
  logic [WIDTH-1:0] sumNext;

  assign accept    = start && (stateQ != RUN);
  assign lastChunk = (cntQ == CW'(N - 1));
  assign chunkSum  = CP1'(aQ[CHUNK-1:0]) + CP1'(bQ[CHUNK-1:0]) + CP1'(carryQ);
  // Each new chunk enters at the top so the LSB chunk ends up at bit 0 after N steps.
  assign sumNext   = (sumQ >> CHUNK) | (WIDTH'(chunkSum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      aQ     <= '0;
      bQ     <= '0;
      sumQ   <= '0;
      cntQ   <= '0;
      carryQ <= 1'b0;
      subQ   <= 1'b0;
      fQ     <= '0;
      cfQ    <= 1'b0;
      zeroQ  <= 1'b0;
      ofQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      aQ     <= aD;
      bQ     <= bD;
      sumQ   <= sumD;
      cntQ   <= cntD;
      carryQ <= carryD;
      subQ   <= subD;
      fQ     <= fD;
      cfQ    <= cfD;
      zeroQ  <= zeroD;
      ofQ    <= ofD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (start) stateD = RUN;
      RUN:     if (lastChunk) stateD = DONE;
      DONE:    stateD = start ? RUN : IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    aD     = aQ;
    bD     = bQ;
    sumD   = sumQ;
    cntD   = cntQ;
    carryD = carryQ;
    subD   = subQ;
    fD     = fQ;
    cfD    = cfQ;
    zeroD  = zeroQ;
    ofD    = ofQ;
    if (accept) begin
      aD     = A;
      bD     = B ^ {WIDTH{addsub}};
      subD   = addsub;
      carryD = addsub;
      cntD   = '0;
      sumD   = '0;
    end else if (stateQ == RUN) begin
      aD     = aQ >> CHUNK;
      bD     = bQ >> CHUNK;
      sumD   = sumNext;
      carryD = chunkSum[CHUNK];
      cntD   = cntQ + CW'(1);
      // On the last step the operand MSBs sit at the top of the low chunk.
      if (lastChunk) begin
        fD    = sumNext;
        cfD   = chunkSum[CHUNK] ^ subQ;
        zeroD = (sumNext == '0);
        ofD   = (aQ[CHUNK-1] == bQ[CHUNK-1]) && (sumNext[WIDTH-1] != aQ[CHUNK-1]);
      end
    end
  end

  always_comb begin
    busy = (stateQ == RUN);
    done = (stateQ == DONE);
  end

  assign F    = fQ;
  assign cf   = cfQ;
  assign zero = zeroQ;
  assign of   = ofQ;

endmodule
